// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - FSM state encoding and count-width helper for seq_mult
package seq_mult_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// rtl/seq_mult_dp.sv - shift-add datapath: operand magnitudes, accumulator, iteration count
// SEQ_MULT_EARLY_TERM_EN: also flag the last iteration once the remaining multiplier bits are zero
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     d1,
    input  logic [WIDTH-1:0]     d2,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [CW-1:0]    count;
    logic             sign;
    logic             neg1;
    logic             neg2;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude
    assign neg1 = (SIGNED != 0) && d1[WIDTH-1];
    assign neg2 = (SIGNED != 0) && d2[WIDTH-1];
    assign mag1 = neg1 ? -d1 : d1;
    assign mag2 = neg2 ? -d2 : d2;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign result   = sign ? -acc_next : acc_next;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last = (count == LAST_COUNT) || (mplier[WIDTH-1:1] == '0);
`else
    assign last = (count == LAST_COUNT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            sign   <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            count  <= '0;
            sign   <= neg1 ^ neg2;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - sequential shift-add multiplier, control FSM and result register
// Optional SEQ_MULT_EARLY_TERM_EN (see seq_mult_dp) shortens latency for small multipliers
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     D1,
    input  logic [WIDTH-1:0]     D2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    logic               state;
    logic               load;
    logic               step;
    logic               last;
    logic               finish;
    logic [2*WIDTH-1:0] result;

    assign busy   = (state == ST_RUN);
    assign load   = (state == ST_IDLE) && start;
    assign step   = (state == ST_RUN);
    assign finish = step && last;

    seq_mult_dp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .d1     (D1),
        .d2     (D2),
        .last   (last),
        .result (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            done <= finish;
            if (load) begin
                state <= ST_RUN;
            end else if (finish) begin
                state <= ST_IDLE;
            end
            if (finish) begin
                out <= result;
            end
        end
    end

endmodule
